gf180mcu_fd_sc_mcu7t5v0__bufpipe: RTL and testbench
===================================================

# gf180mcu_fd_sc_mcu7t5v0__bufpipe

Parametrised, multi-bit, elastic retiming buffer that generalises the single-bit combinational buffer cell. It carries a WIDTH-bit bus through DEPTH registered stages with a valid/ready handshake and reports stage occupancy. Timing-closure tooling inserts it wherever a long buffered route must be retimed without losing back-pressure; DEPTH=0 degenerates to a plain combinational buffer.

## Interface
- WIDTH, 8, data bus width in bits (>=1)
- DEPTH, 2, number of register stages (0..16); 0 = combinational pass-through
- OCC_W, $clog2(DEPTH+1) with minimum 1, width of OCC
- CLK  input  1  clock, all state updates on rising edge
- RN  input  1  asynchronous active-low reset
- I  input  WIDTH  upstream data
- I_VALID  input  1  upstream data valid
- I_READY  output  1  block can accept I this cycle
- Z  output  WIDTH  downstream data (last stage)
- Z_VALID  output  1  Z holds a valid word
- Z_READY  input  1  downstream accepts Z this cycle
- OCC  output  OCC_W  number of stages currently holding valid data
- VDD  inout  1  power, no logical function
- VSS  inout  1  ground, no logical function

## Operation
- One clock (CLK); reset RN is asynchronous, active-low. Decided, not configurable.
- Stages s=0..DEPTH-1, each holds data_s[WIDTH-1:0] and valid_s. Stage 0 faces I; stage DEPTH-1 drives Z/Z_VALID.
- Downstream ready of stage s: rdy_out_s = Z_READY for s=DEPTH-1, else rdy_in_(s+1).
- Stage ready: rdy_in_s = !valid_s || rdy_out_s (combinational ready chain; full throughput, no bubbles).
- I_READY = rdy_in_0.
- Per rising edge, for each stage:
  - load (rdy_in_s && upstream valid): data_s <= upstream data, valid_s <= 1.
  - drain only (valid_s && rdy_out_s && no upstream valid): valid_s <= 0; data_s holds.
  - otherwise: hold data_s and valid_s.
- Transfer at a port occurs only when VALID && READY are both high on a rising edge.
- Z = data_(DEPTH-1); Z_VALID = valid_(DEPTH-1).
- OCC = count of set valid_s, registered (updated with the stages, never combinational from inputs).
- Ordering: words leave in arrival order; no loss, no duplication.
- DEPTH=0: Z=I, Z_VALID=I_VALID, I_READY=Z_READY, OCC=0; no state, CLK/RN unused.
- VDD/VSS carry no logic; they are not referenced by the RTL.

## Timing
- Reset (RN low, asynchronous): all valid_s=0, all data_s=0, OCC=0. Hence Z=0, Z_VALID=0, I_READY=1 (DEPTH>=1).
- Reset deassertion takes effect at the first rising edge with RN high; no synchronisation inside the block.
- Reset mid-operation: all in-flight words discarded immediately; Z_VALID drops without waiting for the clock.
- Latency: a word accepted at edge n appears on Z with Z_VALID=1 after edge n+DEPTH-1 completes... i.e. visible in the cycle following edge n+DEPTH-1 when no stall; DEPTH edges from I to Z registered.
- Throughput: one word per cycle while Z_READY=1.
- Stability: while Z_VALID=1 and Z_READY=0, Z and Z_VALID hold unchanged.
- Full (OCC=DEPTH) with Z_READY=0: I_READY=0; upstream word not taken.
- Full with Z_READY=1: simultaneous push and pop; OCC stays DEPTH.
- Empty (OCC=0): Z_VALID=0; Z retains last data (don't-care to consumers).
- I_READY depends combinationally on Z_READY (documented path; top-level timing must budget it).

## Test plan
- Reset: drive I=8'hA5, I_VALID=1, RN=0 mid-cycle -> Z=0, Z_VALID=0, OCC=0 immediately; I_READY=1.
- Streaming, DEPTH=2: Z_READY=1, push 8'h01..8'h10 back-to-back -> 8'h01 on Z two edges after acceptance, then one word/cycle in order, OCC steady at 2.
- Back-pressure: fill with 8'h11, 8'h22, Z_READY=0 -> OCC=2, I_READY=0, Z=8'h11 held 5 cycles; release Z_READY -> 8'h11, 8'h22 delivered, no loss or duplicate.
- Simultaneous push/pop at full: OCC=2, Z_READY=1, I_VALID=1 I=8'h33 -> 8'h11 popped, 8'h33 accepted, OCC stays 2.
- Reset mid-stream: RN low with OCC=2 -> OCC=0, Z_VALID=0 asynchronously; after release, next push 8'h44 emerges first.
- DEPTH=0, WIDTH=4: I=4'h9, I_VALID=1, Z_READY=0 -> Z=4'h9, Z_VALID=1, I_READY=0 same cycle, OCC=0.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__bufpipe.sv
// Elastic multi-bit retiming buffer: WIDTH-bit bus through DEPTH registered
// stages with a valid/ready handshake and a registered occupancy count.
// DEPTH=0 collapses to a plain combinational buffer with no state.

// One register stage. It loads whenever it has room (empty, or its content
// is leaving this cycle) and upstream offers a word; otherwise it drains or holds.
module gf180mcu_fd_sc_mcu7t5v0__bufpipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             dn_ready_i,
  output logic             rdy_o,
  output logic             valid_o,
  output logic             valid_d_o,
  output logic [WIDTH-1:0] data_o
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Ready chain: room now, or the current word is being taken downstream.
  assign rdy_o     = !valid_q || dn_ready_i;
  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
  assign data_o    = data_q;

  // Next-state: load beats drain; a drained stage keeps its stale data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (rdy_o && up_valid_i) begin
      valid_d = 1'b1;
      data_d  = up_data_i;
    end else if (valid_q && dn_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Stage register, cleared asynchronously so in-flight words vanish at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

module gf180mcu_fd_sc_mcu7t5v0__bufpipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int OCC_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] Z,
  output logic             Z_VALID,
  input  logic             Z_READY,
  output logic [OCC_W-1:0] OCC,
  inout  wire              VDD,
  inout  wire              VSS
);
  if (DEPTH == 0) begin : g_comb
    // No storage: straight wires in both directions.
    assign Z       = I;
    assign Z_VALID = I_VALID;
    assign I_READY = Z_READY;
    assign OCC     = '0;
  end else begin : g_pipe
    // Index s carries what enters stage s; index DEPTH is the output port.
    logic [DEPTH:0]            up_v;
    logic [DEPTH:0][WIDTH-1:0] up_d;
    logic [DEPTH:0]            rdy;
    logic [DEPTH-1:0]          vld_d;
    logic [OCC_W-1:0]          occ_q, occ_d;

    assign up_v[0]    = I_VALID;
    assign up_d[0]    = I;
    assign rdy[DEPTH] = Z_READY;
    assign I_READY    = rdy[0];
    assign Z          = up_d[DEPTH];
    assign Z_VALID    = up_v[DEPTH];
    assign OCC        = occ_q;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      gf180mcu_fd_sc_mcu7t5v0__bufpipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk_i      (CLK),
        .rst_ni     (RN),
        .up_valid_i (up_v[s]),
        .up_data_i  (up_d[s]),
        .dn_ready_i (rdy[s+1]),
        .rdy_o      (rdy[s]),
        .valid_o    (up_v[s+1]),
        .valid_d_o  (vld_d[s]),
        .data_o     (up_d[s+1])
      );
    end

    // Occupancy of the next cycle, so the registered count tracks the stages.
    always_comb begin
      occ_d = '0;
      for (int s = 0; s < DEPTH; s++) occ_d = occ_d + OCC_W'(vld_d[s]);
    end

    // Occupancy register, cleared together with the stages.
    always_ff @(posedge CLK or negedge RN) begin
      if (!RN) occ_q <= '0;
      else     occ_q <= occ_d;
    end
  end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__bufpipe.sv
// Directed bench: DEPTH=2/WIDTH=8 pipe plus a DEPTH=0/WIDTH=4 pass-through.
module tb_gf180mcu_fd_sc_mcu7t5v0__bufpipe;
  logic       clk = 1'b0;
  logic       rn  = 1'b1;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  logic [7:0] i_d = '0;
  logic       i_v = 1'b0, z_r = 1'b0;
  logic       i_r, z_v;
  logic [7:0] z;
  logic [1:0] occ;

  logic [3:0] i0 = '0;
  logic       iv0 = 1'b0, zr0 = 1'b0;
  logic       ir0, zv0;
  logic [3:0] z0;
  logic [0:0] occ0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__bufpipe #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .CLK(clk), .RN(rn), .I(i_d), .I_VALID(i_v), .I_READY(i_r),
    .Z(z), .Z_VALID(z_v), .Z_READY(z_r), .OCC(occ), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__bufpipe #(.WIDTH(4), .DEPTH(0)) u_d0 (
    .CLK(clk), .RN(rn), .I(i0), .I_VALID(iv0), .I_READY(ir0),
    .Z(z0), .Z_VALID(zv0), .Z_READY(zr0), .OCC(occ0), .VDD(vdd), .VSS(vss)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Pass-through buffer, purely combinational.
    i0 = 4'h9; iv0 = 1'b1; zr0 = 1'b0;
    #1;
    chk("d0_z", z0, 4'h9);
    chk("d0_zv", zv0, 1);
    chk("d0_ir_lo", ir0, 0);
    chk("d0_occ", occ0, 0);
    zr0 = 1'b1;
    #1;
    chk("d0_ir_hi", ir0, 1);

    // Asynchronous reset before the first edge, with a word offered.
    #1;
    i_d = 8'hA5; i_v = 1'b1; rn = 1'b0;
    #1;
    chk("rst_z", z, 0);
    chk("rst_zv", z_v, 0);
    chk("rst_occ", occ, 0);
    chk("rst_ir", i_r, 1);
    cyc();
    cyc();
    chk("rst_hold_zv", z_v, 0);
    chk("rst_hold_occ", occ, 0);
    rn = 1'b1; i_v = 1'b0;

    // Streaming 01..10 with Z_READY high.
    z_r = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      i_d = 8'(k + 1);
      i_v = (k < 16);
      cyc();
      if (k == 0) begin
        chk("str_first_zv", z_v, 0);
        chk("str_first_occ", occ, 1);
      end else begin
        chk($sformatf("str_z%0d", k), z, k);
        chk($sformatf("str_zv%0d", k), z_v, 1);
        chk($sformatf("str_occ%0d", k), occ, (k < 16) ? 2 : 1);
      end
    end
    i_v = 1'b0;
    cyc();
    chk("str_empty_zv", z_v, 0);
    chk("str_empty_occ", occ, 0);

    // Back-pressure: fill with 11, 22 while Z_READY is low.
    z_r = 1'b0;
    i_d = 8'h11; i_v = 1'b1;
    cyc();
    i_d = 8'h22;
    cyc();
    chk("bp_full_occ", occ, 2);
    i_d = 8'h55;
    #1;
    chk("bp_ir", i_r, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("bp_hold_z%0d", k), z, 8'h11);
      chk($sformatf("bp_hold_zv%0d", k), z_v, 1);
      chk($sformatf("bp_hold_occ%0d", k), occ, 2);
    end

    // Release with a push at full: 11 leaves, 33 enters, occupancy stays 2.
    z_r = 1'b1; i_d = 8'h33; i_v = 1'b1;
    #1;
    chk("pp_ir", i_r, 1);
    cyc();
    chk("pp_z", z, 8'h22);
    chk("pp_occ", occ, 2);
    i_v = 1'b0;
    cyc();
    chk("pp_z2", z, 8'h33);
    chk("pp_occ2", occ, 1);

    // Stall 33 and add 66 behind it, then reset mid-cycle.
    z_r = 1'b0; i_d = 8'h66; i_v = 1'b1;
    cyc();
    chk("mr_occ_pre", occ, 2);
    i_v = 1'b0;
    #2;
    rn = 1'b0;
    #1;
    chk("mr_occ", occ, 0);
    chk("mr_zv", z_v, 0);
    chk("mr_z", z, 0);
    chk("mr_ir", i_r, 1);
    cyc();
    rn = 1'b1;

    // After release, 44 is the first word out.
    z_r = 1'b1; i_d = 8'h44; i_v = 1'b1;
    cyc();
    chk("mr_after_zv0", z_v, 0);
    i_v = 1'b0;
    cyc();
    chk("mr_after_z", z, 8'h44);
    chk("mr_after_zv", z_v, 1);
    chk("mr_after_occ", occ, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
